pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
// Generic parametrised pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries an opaque DW-bit stage bundle using a valid/ready handshake, with synchronous flush.
// An optional 2-entry skid buffer registers in_ready and breaks the backpressure timing path.
// Replaces hand-written per-stage latches that could only flush, and could not stall or backpressure.
// PARAMETERS
// DW         32   width of the packed stage bundle (in_data/out_data)
// SKID       1    1: 2-entry skid buffer with registered in_ready; 0: single entry with combinational in_ready
// FLUSH_VAL  '0   value driven on out_data while empty, after flush, and out of reset (NOP bundle)
// CW         16   width of the occupancy statistics counters
// PORTS
// CLK        in   1    clock, rising edge
// nRST       in   1    reset, asynchronous, active-low
// in_valid   in   1    upstream stage holds a valid bundle
// in_ready   out  1    this stage accepts in_data at this edge
// in_data    in   DW   upstream bundle
// flush      in   1    kill all held entries and any entry accepted this cycle
// out_valid  out  1    out_data holds a valid bundle
// out_ready  in   1    downstream consumes out_data at this edge
// out_data   out  DW   bundle presented to the downstream stage
// bubble_cnt out  CW   cycles with out_valid=0 (saturating)
// stall_cnt  out  CW   cycles with out_valid=1 && out_ready=0 (saturating)
// BEHAVIOUR
// - Reset (async, nRST=0): entries invalid, out_valid=0, out_data=FLUSH_VAL, counters=0.
//   SKID=1: in_ready=1 from the first edge after reset release.
// - Transfers: in_xfer = in_valid&&in_ready; out_xfer = out_valid&&out_ready. Each transfers exactly one bundle per edge.
// - Latency: 1 cycle. A bundle accepted at edge N appears on out_data after edge N, provided the stage was empty.
// - SKID=0:
//   - in_ready = !out_valid || out_ready (combinational).
//   - Main entry loads on in_xfer, clears on out_xfer without in_xfer.
// - SKID=1 FSM (state reg; in_ready = state!=FULL, registered):
//   - EMPTY -in_xfer-> ONE
//   - ONE -in_xfer&&!out_xfer-> FULL (bundle captured into skid)
//   - ONE -out_xfer&&!in_xfer-> EMPTY
//   - ONE -in_xfer&&out_xfer-> ONE (main reloads)
//   - FULL -out_xfer-> ONE (skid moves to main; no new accept since in_ready=0)
// - Ordering: strict FIFO. The skid entry is never presented before the main entry.
// - Data: out_data = main entry when out_valid, else FLUSH_VAL.
//   Held data is stable while out_valid && !out_ready (no change on any bit).
// - Flush (sync):
//   - Next state is EMPTY/invalid and out_data=FLUSH_VAL, regardless of in_valid/out_ready.
//   - A bundle handshaken on the flush edge is discarded (in_ready is not forced low).
//   - An out_xfer on the flush edge still counts as delivered.
//   - Flush has priority over all loads.
// - Reset mid-operation: async clear of all entries; in-flight bundles are lost; no handshake completes.
// - Counters: +1 per qualifying cycle, saturating at 2**CW-1, and not cleared by flush.
// - Invariants (assertions):
//   - out_valid && !out_ready holds out_valid and out_data next cycle (unless flush).
//   - SKID=1: never more than 2 bundles held.
//   - X on in_data is ignored when !in_valid.
// STRUCTURE
// - pipe_pkg: typedef stage_state_t {EMPTY, ONE, FULL}; localparam NOP_BUNDLE.
// - pipe_pkg: per-stage packed bundle structs (idex_t, exmem_t, ...) that instantiations cast to DW via $bits.
// - One sub-module: pipe_skid_buf (the SKID=1 storage and FSM), selected by generate.
// - Counters stay inline in pipe_stage_reg.
// TESTING
// - Reset: nRST=0 mid-stream -> out_valid=0, out_data=FLUSH_VAL, counters=0; SKID=1 in_ready=1 after release.
// - Streaming: in_valid=1, out_ready=1, data 0x1..0x8 -> out_data 0x1..0x8 one per cycle, 1-cycle latency, no gaps.
// - Backpressure (SKID=1): out_ready=0 while sending 0xA, 0xB, 0xC.
//   -> 0xA held; 0xB in skid; in_ready=0; 0xC waits.
//   -> On out_ready=1, outputs are 0xA, 0xB, 0xC in order; stall_cnt counts the held cycles.
// - Flush while FULL with in_xfer of 0xD -> next cycle out_valid=0, out_data=FLUSH_VAL, 0xD never appears.
// - Simultaneous in_xfer/out_xfer in ONE -> state stays ONE and out_data updates each cycle.
//   SKID=0 gives the same stream as SKID=1 for a random valid/ready pattern.
// - Saturation: CW=4, hold empty 20 cycles -> bubble_cnt=15 and stays 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers.
// Stage bundles are cast to DW bits with $bits when instantiated.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } stage_state_t;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam logic [31:0] NOP_BUNDLE = 32'h0000_0000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        use_imm;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb_en;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb_en;
    } exmem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } memwb_t;

    function automatic ifid_t ifid_nop(input logic [31:0] pc);
        ifid_t b;
        b.pc   = pc;
        b.insn = NOP_INSN;
        return b;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid storage for a pipeline boundary.
// in_ready comes straight from a flop, so backpressure does not ripple upstream.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   FLUSH_VAL = '0
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    stage_state_t  state;
    logic          rdy_q;
    logic          vld_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer   = in_valid && rdy_q;
    assign out_xfer  = vld_q && out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_data  = main_q;

    // Occupancy FSM; main_q is the presented entry, skid_q the overflow one.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= EMPTY;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            main_q <= FLUSH_VAL;
            skid_q <= FLUSH_VAL;
        end else if (flush) begin
            state  <= EMPTY;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            main_q <= FLUSH_VAL;
        end else begin
            rdy_q <= 1'b1;
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state  <= ONE;
                        vld_q  <= 1'b1;
                        main_q <= in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state  <= FULL;
                        rdy_q  <= 1'b0;
                        skid_q <= in_data;
                    end else if (out_xfer && !in_xfer) begin
                        state  <= EMPTY;
                        vld_q  <= 1'b0;
                        main_q <= FLUSH_VAL;
                    end else if (in_xfer) begin
                        main_q <= in_data;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    vld_q  <= 1'b0;
                    main_q <= FLUSH_VAL;
                end
            endcase
        end
    end

    // At most two bundles, and the flags must agree with the state.
    a_state_legal: assert property (
        @(posedge CLK) disable iff (!nRST)
        state inside {EMPTY, ONE, FULL}
    );

    a_vld_state: assert property (
        @(posedge CLK) disable iff (!nRST)
        vld_q == (state != EMPTY)
    );

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with synchronous flush.
// Optional skid storage; occupancy statistics counters kept here.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int            DW        = 32,
    parameter bit            SKID      = 1'b1,
    parameter logic [DW-1:0] FLUSH_VAL = DW'(NOP_BUNDLE),
    parameter int            CW        = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] bubble_cnt,
    output logic [CW-1:0] stall_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    if (SKID) begin : g_skid
        pipe_skid_buf #(
            .DW        (DW),
            .FLUSH_VAL (FLUSH_VAL)
        ) u_buf (
            .CLK       (CLK),
            .nRST      (nRST),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .flush     (flush),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
        );
    end else begin : g_single
        logic          vld_q;
        logic [DW-1:0] main_q;

        assign in_ready  = !vld_q || out_ready;
        assign out_valid = vld_q;
        assign out_data  = main_q;

        // Single entry: reload on accept, drop back to the NOP bundle on drain.
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                vld_q  <= 1'b0;
                main_q <= FLUSH_VAL;
            end else if (flush) begin
                vld_q  <= 1'b0;
                main_q <= FLUSH_VAL;
            end else if (in_valid && in_ready) begin
                vld_q  <= 1'b1;
                main_q <= in_data;
            end else if (vld_q && out_ready) begin
                vld_q  <= 1'b0;
                main_q <= FLUSH_VAL;
            end
        end
    end

    // Saturating occupancy statistics; survive flush, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (!out_valid && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // A stalled bundle must stay put until consumed or flushed.
    a_hold: assert property (
        @(posedge CLK) disable iff (!nRST)
        (out_valid && !out_ready && !flush)
            |=> (out_valid && $stable(out_data))
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg (SKID=1, SKID=0, CW=4).
// Reference is a queue-based occupancy model checked every negedge.
module tb_pipe_stage_reg;

    localparam int            DW = 32;
    localparam logic [DW-1:0] FV = 32'h0000_0013;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic          iv1 = 1'b0, iv0 = 1'b0, ivs = 1'b0;
    logic [DW-1:0] id1 = '0, id0 = '0, ids = '0;
    logic          orr = 1'b1, fl = 1'b0;

    logic          rdy1, rdy0, rdys;
    logic          ov1, ov0, ovs;
    logic [DW-1:0] od1, od0, ods;
    logic [15:0]   bub1, stl1, bub0, stl0;
    logic [3:0]    bubs, stls;

    pipe_stage_reg #(.DW(DW), .SKID(1'b1), .FLUSH_VAL(FV), .CW(16)) dut1 (
        .CLK(CLK), .nRST(nRST), .in_valid(iv1), .in_ready(rdy1),
        .in_data(id1), .flush(fl), .out_valid(ov1), .out_ready(orr),
        .out_data(od1), .bubble_cnt(bub1), .stall_cnt(stl1)
    );

    pipe_stage_reg #(.DW(DW), .SKID(1'b0), .FLUSH_VAL(FV), .CW(16)) dut0 (
        .CLK(CLK), .nRST(nRST), .in_valid(iv0), .in_ready(rdy0),
        .in_data(id0), .flush(fl), .out_valid(ov0), .out_ready(orr),
        .out_data(od0), .bubble_cnt(bub0), .stall_cnt(stl0)
    );

    pipe_stage_reg #(.DW(DW), .SKID(1'b1), .FLUSH_VAL(FV), .CW(4)) duts (
        .CLK(CLK), .nRST(nRST), .in_valid(ivs), .in_ready(rdys),
        .in_data(ids), .flush(1'b0), .out_valid(ovs), .out_ready(1'b1),
        .out_data(ods), .bubble_cnt(bubs), .stall_cnt(stls)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%h required=%h t=%0t",
                         n, act, req, $time);
        end
    endtask

    // Behavioural model: FIFO contents, SKID=1 ready flag, counters.
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    bit            mr1 = 1'b0;
    int unsigned   b1 = 0, s1 = 0, b0 = 0, s0 = 0, bs = 0;

    function automatic int unsigned sat(input int unsigned v,
                                        input int unsigned mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        bit ix1, ox1, ix0, ox0;
        if (!nRST) begin
            q1.delete();
            q0.delete();
            mr1 = 1'b0;
            b1 = 0; s1 = 0; b0 = 0; s0 = 0; bs = 0;
        end else begin
            if (q1.size() == 0) b1 = sat(b1, 65535);
            else if (!orr)      s1 = sat(s1, 65535);
            if (q0.size() == 0) b0 = sat(b0, 65535);
            else if (!orr)      s0 = sat(s0, 65535);
            bs  = sat(bs, 15);
            ix1 = iv1 && mr1;
            ox1 = (q1.size() > 0) && orr;
            ix0 = iv0 && ((q0.size() == 0) || orr);
            ox0 = (q0.size() > 0) && orr;
            if (fl) begin
                q1.delete();
                q0.delete();
            end else begin
                if (ox1) void'(q1.pop_front());
                if (ix1) q1.push_back(id1);
                if (ox0) void'(q0.pop_front());
                if (ix0) q0.push_back(id0);
            end
            mr1 = (q1.size() < 2);
        end
    end

    bit            rec = 1'b0;
    logic [DW-1:0] del1[$];
    logic [DW-1:0] del0[$];

    // Every-cycle comparison against the model, plus delivered-stream capture.
    always @(negedge CLK) begin
        chk("v1", 32'(ov1), 32'(q1.size() > 0));
        chk("d1", od1, (q1.size() > 0) ? q1[0] : FV);
        chk("r1", 32'(rdy1), 32'(mr1));
        chk("bub1", 32'(bub1), b1);
        chk("stl1", 32'(stl1), s1);
        chk("v0", 32'(ov0), 32'(q0.size() > 0));
        chk("d0", od0, (q0.size() > 0) ? q0[0] : FV);
        chk("r0", 32'(rdy0), 32'((q0.size() == 0) || orr));
        chk("bub0", 32'(bub0), b0);
        chk("stl0", 32'(stl0), s0);
        chk("bubs", 32'(bubs), bs);
        chk("stls", 32'(stls), 32'd0);
        if (rec && nRST) begin
            if (ov1 && orr) del1.push_back(od1);
            if (ov0 && orr) del0.push_back(od0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        iv1 = v; id1 = d;
        iv0 = v; id0 = d;
    endtask

    int k1, k0;
    bit a1, a0;

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_v1", 32'(ov1), 32'd0);
        chk("rst_d1", od1, FV);
        chk("rst_bub1", 32'(bub1), 32'd0);
        chk("rst_stl1", 32'(stl1), 32'd0);
        nRST = 1'b1;
        step();
        chk("rel_r1", 32'(rdy1), 32'd1);
        chk("rel_bub1", 32'(bub1), 32'd1);

        // Streaming 1..8, one per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i));
            step();
            chk("stream_v", 32'(ov1), 32'd1);
            chk("stream_d", od1, DW'(i));
        end
        drive(1'b0, '0);
        step();
        chk("stream_end_v", 32'(ov1), 32'd0);
        chk("stream_end_d", od1, FV);

        // Backpressure A, B, C
        orr = 1'b0;
        drive(1'b1, 32'hA);
        step();
        chk("bp_a", od1, 32'hA);
        drive(1'b1, 32'hB);
        step();
        chk("bp_full_r", 32'(rdy1), 32'd0);
        chk("bp_hold_a", od1, 32'hA);
        drive(1'b1, 32'hC);
        step();
        step();
        chk("bp_hold_a2", od1, 32'hA);
        chk("bp_stall", 32'(stl1), 32'd3);
        orr = 1'b1;
        step();
        chk("bp_b", od1, 32'hB);
        chk("bp_r_back", 32'(rdy1), 32'd1);
        step();
        chk("bp_c", od1, 32'hC);
        drive(1'b0, '0);
        step();
        chk("bp_drained", 32'(ov1), 32'd0);
        chk("bp_stall_kept", 32'(stl1), 32'd3);

        // Flush while FULL, with D offered
        orr = 1'b0;
        drive(1'b1, 32'h21);
        step();
        drive(1'b1, 32'h22);
        step();
        drive(1'b1, 32'hD);
        fl = 1'b1;
        step();
        fl = 1'b0;
        chk("fl_full_v", 32'(ov1), 32'd0);
        chk("fl_full_d", od1, FV);
        chk("fl_full_r", 32'(rdy1), 32'd1);
        drive(1'b0, '0);
        orr = 1'b1;
        repeat (3) begin
            step();
            chk("fl_no_d", 32'(ov1), 32'd0);
        end

        // Flush in ONE with a real handshake of D
        drive(1'b1, 32'hE);
        step();
        chk("one_e", od1, 32'hE);
        orr = 1'b0;
        drive(1'b1, 32'hD);
        fl = 1'b1;
        step();
        fl = 1'b0;
        orr = 1'b1;
        drive(1'b0, '0);
        chk("fl_one_v", 32'(ov1), 32'd0);
        chk("fl_one_d", od1, FV);
        step();
        chk("fl_one_gone", 32'(ov1), 32'd0);

        // Asynchronous reset while FULL
        orr = 1'b0;
        drive(1'b1, 32'h31);
        step();
        drive(1'b1, 32'h32);
        step();
        #2;
        nRST = 1'b0;
        #1;
        chk("mrst_v1", 32'(ov1), 32'd0);
        chk("mrst_d1", od1, FV);
        chk("mrst_bub1", 32'(bub1), 32'd0);
        chk("mrst_stl1", 32'(stl1), 32'd0);
        chk("mrst_v0", 32'(ov0), 32'd0);
        drive(1'b0, '0);
        orr = 1'b1;
        step();
        nRST = 1'b1;
        step();
        chk("mrst_r1", 32'(rdy1), 32'd1);

        // Saturation of the CW=4 bubble counter
        repeat (19) step();
        chk("sat_bubs", 32'(bubs), 32'd15);
        chk("sat_bub1", 32'(bub1), 32'd20);
        repeat (5) step();
        chk("sat_bubs_hold", 32'(bubs), 32'd15);

        // Random valid/ready streams, separate sources per instance
        k1 = 0;
        k0 = 0;
        rec = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            orr = ($urandom_range(0, 3) != 0);
            iv1 = ($urandom_range(0, 2) != 0);
            iv0 = ($urandom_range(0, 2) != 0);
            id1 = iv1 ? 32'h1000 + 32'(k1) : 'x;
            id0 = iv0 ? 32'h1000 + 32'(k0) : 'x;
            @(negedge CLK);
            a1 = iv1 && rdy1;
            a0 = iv0 && rdy0;
            @(posedge CLK);
            #1;
            if (a1) k1++;
            if (a0) k0++;
        end
        drive(1'b0, '0);
        orr = 1'b1;
        repeat (4) step();
        rec = 1'b0;
        chk("rnd_cnt1", 32'(del1.size()), 32'(k1));
        chk("rnd_cnt0", 32'(del0.size()), 32'(k0));
        chk("rnd_busy", 32'(k1 > 200), 32'd1);
        foreach (del1[i]) chk("rnd_ord1", del1[i], 32'h1000 + 32'(i));
        foreach (del0[i]) chk("rnd_ord0", del0[i], 32'h1000 + 32'(i));
        for (int i = 0; i < del0.size() && i < del1.size(); i++)
            chk("skid_vs_single", del0[i], del1[i]);

        // Random traffic with occasional flushes
        for (int c = 0; c < 500; c++) begin
            orr = ($urandom_range(0, 3) != 0);
            iv1 = ($urandom_range(0, 1) != 0);
            iv0 = iv1;
            id1 = iv1 ? $urandom : 'x;
            id0 = id1;
            fl  = ($urandom_range(0, 15) == 0);
            step();
        end
        fl = 1'b0;
        drive(1'b0, '0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
